// File: rtl/qspi_cmd_ctrl.sv
// QSPI command front end: parses opcode/address/length headers from the RX FIFO
// and turns them into single-byte memory writes or memory reads pushed to the TX FIFO.
module qspi_cmd_ctrl #(
  parameter  int ADDR_BYTES = 2,
  localparam int ADDR_W     = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              async_nreset,
  input  logic [7:0]        rd_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  output logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              closed,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [7:0]        err_count
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CMD     = 4'd1;
  localparam logic [3:0] S_ADDR    = 4'd2;
  localparam logic [3:0] S_LEN     = 4'd3;
  localparam logic [3:0] S_WR_DATA = 4'd4;
  localparam logic [3:0] S_WR_MEM  = 4'd5;
  localparam logic [3:0] S_RD_MEM  = 4'd6;
  localparam logic [3:0] S_RD_PUSH = 4'd7;
  localparam logic [3:0] S_SKIP    = 4'd8;

  logic [3:0] state_reg;
  logic [8:0] count_reg;
  logic [3:0] abyte_reg;
  logic       is_read_reg;
  logic       abort_reg;
  logic       pop;

  // Header states refuse bytes while closed so the abort wins over a same-cycle byte.
  always_comb begin
    pop = 1'b0;
    case (state_reg)
      S_IDLE:                            pop = rd_valid & closed;
      S_CMD, S_ADDR, S_LEN, S_WR_DATA:   pop = rd_valid & ~closed;
      S_SKIP:                            pop = rd_valid;
      default:                           pop = 1'b0;
    endcase
  end

  assign rd_ready = pop & async_nreset;
  assign wr_ready = (state_reg == S_RD_PUSH) & wr_valid & ~closed;
  assign mem_wr   = (state_reg == S_WR_MEM);
  assign mem_rd   = (state_reg == S_RD_MEM);
  assign busy     = (state_reg != S_IDLE);

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state_reg   <= S_IDLE;
      count_reg   <= '0;
      abyte_reg   <= '0;
      is_read_reg <= 1'b0;
      abort_reg   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wr_data     <= '0;
      err_count   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (!closed) state_reg <= S_CMD;
        end
        S_CMD: begin
          if (closed) begin
            state_reg <= S_IDLE;
          end else if (rd_valid) begin
            abyte_reg <= '0;
            abort_reg <= 1'b0;
            case (rd_data[7:6])
              2'b00: begin is_read_reg <= 1'b0; state_reg <= S_ADDR; end
              2'b01: begin is_read_reg <= 1'b1; state_reg <= S_ADDR; end
              default: begin
                state_reg <= S_SKIP;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (closed) begin
            state_reg <= S_IDLE;
          end else if (rd_valid) begin
            mem_addr <= (mem_addr << 8) | ADDR_W'(rd_data);
            if (abyte_reg == 4'(ADDR_BYTES - 1)) state_reg <= S_LEN;
            else                                 abyte_reg <= abyte_reg + 4'd1;
          end
        end
        S_LEN: begin
          if (closed) begin
            state_reg <= S_IDLE;
          end else if (rd_valid) begin
            count_reg <= (rd_data == 8'd0) ? 9'd256 : {1'b0, rd_data};
            state_reg <= is_read_reg ? S_RD_MEM : S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (closed) begin
            state_reg <= S_IDLE;
          end else if (rd_valid) begin
            mem_wdata <= rd_data;
            state_reg <= S_WR_MEM;
          end
        end
        S_WR_MEM: begin
          // A close seen while the request is outstanding is remembered until it completes.
          if (mem_ready) begin
            abort_reg <= 1'b0;
            mem_addr  <= mem_addr + ADDR_W'(1);
            count_reg <= count_reg - 9'd1;
            if (closed || abort_reg)     state_reg <= S_IDLE;
            else if (count_reg == 9'd1)  state_reg <= S_SKIP;
            else                         state_reg <= S_WR_DATA;
          end else begin
            abort_reg <= abort_reg | closed;
          end
        end
        S_RD_MEM: begin
          if (mem_ready) begin
            abort_reg <= 1'b0;
            wr_data   <= mem_rdata;
            state_reg <= (closed || abort_reg) ? S_IDLE : S_RD_PUSH;
          end else begin
            abort_reg <= abort_reg | closed;
          end
        end
        S_RD_PUSH: begin
          if (closed) begin
            state_reg <= S_IDLE;
          end else if (wr_valid) begin
            mem_addr  <= mem_addr + ADDR_W'(1);
            count_reg <= count_reg - 9'd1;
            state_reg <= (count_reg == 9'd1) ? S_SKIP : S_RD_MEM;
          end
        end
        S_SKIP: begin
          if (closed) state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qspi_cmd_ctrl.sv
// Bench for qspi_cmd_ctrl: FIFO/memory responders, a command-level model feeding
// expectation queues, and one per-cycle compare process.
module tb_qspi_cmd_ctrl;

  logic        clk = 1'b0;
  logic        async_nreset;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        closed;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic        busy;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  qspi_cmd_ctrl #(.ADDR_BYTES(2)) dut (
    .clk(clk), .async_nreset(async_nreset),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .closed(closed),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .err_count(err_count)
  );

  typedef struct packed {
    logic        is_rd;
    logic [15:0] addr;
    logic [7:0]  data;
  } mem_op_t;

  int n_tests = 0;
  int n_fail  = 0;

  mem_op_t    exp_mem_q[$];
  logic [7:0] exp_push_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rresp_q[$];
  mem_op_t    mem_log[$];
  logic [7:0] push_log[$];
  logic [7:0] cmd[$];
  logic [7:0] rdsrc[$];

  int hold_cycles  = 1;
  int tx_block_cfg = 0;
  int err_exp      = 0;
  int pushes       = 0;
  int last_rd_run  = 0;
  int rd_run       = 0;
  int since_rd     = 0;
  int req_cycles   = 0;
  int blk          = 0;
  bit pop_rx_flag  = 1'b0;
  bit rresp_flag   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RX FIFO, memory and TX FIFO responders; inputs change on the falling edge.
  always @(negedge clk) begin
    if (pop_rx_flag && rx_q.size() > 0) rx_q.delete(0);
    if (rresp_flag) begin
      if (rresp_q.size() > 0) rresp_q.delete(0);
      blk = tx_block_cfg;
    end
    pop_rx_flag = 1'b0;
    rresp_flag  = 1'b0;
    rd_valid  = (rx_q.size() > 0);
    rd_data   = rd_valid ? rx_q[0] : 8'h00;
    mem_rdata = (rresp_q.size() > 0) ? rresp_q[0] : 8'h00;
    if (mem_wr || mem_rd) begin
      mem_ready  = (req_cycles >= hold_cycles - 1);
      req_cycles = mem_ready ? 0 : req_cycles + 1;
    end else begin
      mem_ready  = 1'b0;
      req_cycles = 0;
    end
    wr_valid = (blk == 0);
    if (blk > 0) blk--;
  end

  logic        prev_req = 1'b0;
  logic        prev_done = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_wdata = '0;
  mem_op_t     cmp_e;
  mem_op_t     cmp_got;

  // Compare process: sampled 1 ns before the rising edge, when every input is settled.
  always @(negedge clk) begin
    #4;
    if (async_nreset) begin
      pop_rx_flag = rd_valid && rd_ready;
      check("mem_rd_wr_exclusive", 32'(mem_rd & mem_wr), 32'd0);
      if (wr_ready) check("wr_ready_needs_wr_valid", 32'(wr_valid), 32'd1);
      if ((mem_wr || mem_rd) && prev_req && !prev_done) begin
        check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
        if (mem_wr) check("mem_wdata_stable", 32'(mem_wdata), 32'(prev_wdata));
      end
      rd_run = mem_rd ? rd_run + 1 : 0;
      since_rd++;
      if ((mem_wr || mem_rd) && mem_ready) begin
        cmp_got.is_rd = mem_rd;
        cmp_got.addr  = mem_addr;
        cmp_got.data  = mem_wr ? mem_wdata : 8'h00;
        mem_log.push_back(cmp_got);
        check("mem_access_expected", 32'(exp_mem_q.size() != 0), 32'd1);
        if (exp_mem_q.size() != 0) begin
          cmp_e = exp_mem_q.pop_front();
          check("mem_op_kind", 32'(mem_rd), 32'(cmp_e.is_rd));
          check("mem_op_addr", 32'(mem_addr), 32'(cmp_e.addr));
          if (mem_wr) check("mem_op_wdata", 32'(mem_wdata), 32'(cmp_e.data));
        end
        if (mem_rd) begin
          rresp_flag  = 1'b1;
          since_rd    = 0;
          last_rd_run = rd_run;
        end
      end
      if (wr_ready) begin
        pushes++;
        push_log.push_back(wr_data);
        check("push_expected", 32'(exp_push_q.size() != 0), 32'd1);
        if (exp_push_q.size() != 0) check("push_wr_data", 32'(wr_data), 32'(exp_push_q.pop_front()));
        check("push_latency", since_rd, tx_block_cfg + 1);
      end
      prev_req   = mem_wr || mem_rd;
      prev_done  = mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
    end else begin
      prev_req    = 1'b0;
      rd_run      = 0;
      pop_rx_flag = 1'b0;
    end
  end

  // Command-level model: what memory traffic and TX pushes the header implies.
  task automatic model_cmd(input bit no_push);
    logic [15:0] a;
    int          n;
    mem_op_t     e;
    if (cmd[0][7]) begin
      err_exp = (err_exp == 255) ? 255 : err_exp + 1;
    end else begin
      a = {cmd[1], cmd[2]};
      n = (cmd[3] == 8'd0) ? 256 : 32'(cmd[3]);
      for (int i = 0; i < n; i++) begin
        e.is_rd = cmd[0][6];
        e.addr  = a + 16'(i);
        e.data  = cmd[0][6] ? 8'h00 : cmd[4 + i];
        exp_mem_q.push_back(e);
        if (cmd[0][6]) begin
          rresp_q.push_back(rdsrc[i]);
          if (!no_push) exp_push_q.push_back(rdsrc[i]);
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic start_cmd();
    step();
    closed = 1'b0;
    foreach (cmd[i]) rx_q.push_back(cmd[i]);
  endtask

  task automatic finish_cmd(input string name);
    int k;
    k = 0;
    while ((rx_q.size() != 0 || exp_mem_q.size() != 0 || exp_push_q.size() != 0) && k < 3000) begin
      step();
      k++;
    end
    check({name, "_drain_in_time"}, 32'(k < 3000), 32'd1);
    step();
    step();
    closed = 1'b1;
    k = 0;
    while (busy && k < 20) begin
      step();
      k++;
    end
    check({name, "_idle_after_close"}, 32'(busy), 32'd0);
    check({name, "_err_count"}, 32'(err_count), err_exp);
  endtask

  task automatic run_cmd(input string name);
    model_cmd(1'b0);
    start_cmd();
    finish_cmd(name);
  endtask

  int base;
  int k;

  initial begin
    async_nreset = 1'b0;
    closed       = 1'b1;
    rd_valid     = 1'b0;
    rd_data      = 8'h00;
    wr_valid     = 1'b1;
    mem_ready    = 1'b0;
    mem_rdata    = 8'h00;
    rx_q.push_back(8'h99);

    // Reset values, including rd_ready held low despite a stale byte with closed=1.
    step(); step();
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_wr_rd", 32'({mem_wr, mem_rd, wr_ready}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    async_nreset = 1'b1;
    step(); step(); step();
    check("idle_purge", rx_q.size(), 0);

    // Two-byte write at 0x1234.
    base = mem_log.size();
    cmd = {8'h00, 8'h12, 8'h34, 8'h02, 8'hAA, 8'hBB};
    run_cmd("write2");
    check("write2_count", mem_log.size() - base, 2);
    check("write2_addr0", 32'(mem_log[base].addr), 32'h1234);
    check("write2_data0", 32'(mem_log[base].data), 32'hAA);
    check("write2_addr1", 32'(mem_log[base + 1].addr), 32'h1235);
    check("write2_data1", 32'(mem_log[base + 1].data), 32'hBB);

    // Two-byte read wrapping 0xFFFF -> 0x0000.
    base = push_log.size();
    k = mem_log.size();
    cmd = {8'h40, 8'hFF, 8'hFF, 8'h02};
    rdsrc = {8'h11, 8'h22};
    run_cmd("read_wrap");
    check("read_wrap_addr0", 32'(mem_log[k].addr), 32'hFFFF);
    check("read_wrap_addr1", 32'(mem_log[k + 1].addr), 32'h0000);
    check("read_wrap_pushes", push_log.size() - base, 2);
    check("read_wrap_push0", 32'(push_log[base]), 32'h11);
    check("read_wrap_push1", 32'(push_log[base + 1]), 32'h22);

    // TX backpressure for 10 cycles; latency is checked by the compare process.
    tx_block_cfg = 10;
    base = pushes;
    cmd = {8'h40, 8'h00, 8'h20, 8'h01};
    rdsrc = {8'h5A};
    run_cmd("backpressure");
    check("backpressure_pushes", pushes - base, 1);
    tx_block_cfg = 0;

    // Invalid opcode with trailing bytes.
    base = mem_log.size();
    cmd = {8'hC0, 8'h01, 8'h02, 8'h03};
    run_cmd("invalid");
    check("invalid_err_count_lit", 32'(err_count), 32'd1);
    check("invalid_no_mem", mem_log.size() - base, 0);

    // Length 0 means 256 bytes, with address wrap partway through.
    cmd = {8'h00, 8'hFF, 8'h80, 8'h00};
    for (int i = 0; i < 256; i++) cmd.push_back(8'(i) ^ 8'h3C);
    base = mem_log.size();
    run_cmd("write256");
    check("write256_count", mem_log.size() - base, 256);
    check("write256_last_addr", 32'(mem_log[base + 255].addr), 32'h007F);

    // Abort inside the header: partial address, then close.
    base = mem_log.size();
    cmd = {8'h00, 8'h12};
    start_cmd();
    finish_cmd("hdr_abort");
    check("hdr_abort_no_mem", mem_log.size() - base, 0);

    // Close while a slow read is pending: request completes, no push.
    hold_cycles = 5;
    base = pushes;
    cmd = {8'h40, 8'h00, 8'h10, 8'h01};
    rdsrc = {8'h77};
    model_cmd(1'b1);
    start_cmd();
    k = 0;
    while (!mem_rd && k < 50) begin step(); k++; end
    check("rd_abort_mem_rd_seen", 32'(mem_rd), 32'd1);
    closed = 1'b1;
    k = 0;
    while (busy && k < 30) begin step(); k++; end
    check("rd_abort_idle", 32'(busy), 32'd0);
    check("rd_abort_hold_cycles", last_rd_run, 5);
    check("rd_abort_no_push", pushes - base, 0);
    check("rd_abort_read_done", exp_mem_q.size(), 0);
    hold_cycles = 1;

    // 256 invalid commands saturate the error counter.
    for (int i = 0; i < 256; i++) begin
      cmd = {8'h80};
      run_cmd("invalid_sat");
    end
    check("err_count_saturated", 32'(err_count), 32'd255);

    // Reset in the middle of a pending write.
    hold_cycles = 8;
    cmd = {8'h00, 8'h00, 8'h50, 8'h01, 8'hE1};
    model_cmd(1'b0);
    start_cmd();
    k = 0;
    while (!mem_wr && k < 50) begin step(); k++; end
    check("rst_mid_mem_wr_seen", 32'(mem_wr), 32'd1);
    async_nreset = 1'b0;
    #1;
    check("rst_mid_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_err_count", 32'(err_count), 32'd0);
    check("rst_mid_mem_addr", 32'(mem_addr), 32'd0);
    exp_mem_q.delete();
    exp_push_q.delete();
    rx_q.delete();
    rresp_q.delete();
    err_exp = 0;
    closed = 1'b1;
    hold_cycles = 1;
    step(); step();
    async_nreset = 1'b1;
    step();

    // Normal operation resumes after reset.
    base = mem_log.size();
    cmd = {8'h00, 8'h12, 8'h34, 8'h01, 8'h5C};
    run_cmd("post_reset_write");
    check("post_reset_count", mem_log.size() - base, 1);
    check("post_reset_data", 32'(mem_log[base].data), 32'h5C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
